// File: rtl/mbus_rx_channel_filter.sv
// RX-side channel filter between the bus node RX port and the host RX port.
// Broadcast messages on channels selected by DROP_MASK are acknowledged
// locally. All other messages are forwarded to the host over a registered
// four-phase handshake. A host-ACK timeout keeps a stalled host from hanging
// the node. Saturating drop and timeout counters are exported for debug.
module mbus_rx_channel_filter #(
    parameter int unsigned FUNC_WIDTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_CH      = 16,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned TMR_WIDTH   = 11,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  CLK_EXT,
    input  logic                  RESETn,
    input  logic                  MASTER_EN,
    input  logic [NUM_CH-1:0]     DROP_MASK,
    input  logic [ADDR_WIDTH-1:0] NODE_RX_ADDR,
    input  logic                  NODE_RX_BROADCAST,
    input  logic                  NODE_RX_REQ,
    output logic                  NODE_RX_ACK,
    output logic                  HOST_RX_REQ,
    input  logic                  HOST_RX_ACK,
    output logic                  TIMEOUT,
    output logic [CNT_WIDTH-1:0]  DROP_COUNT,
    output logic [CNT_WIDTH-1:0]  TIMEOUT_COUNT
);

    // Timer value on which the timeout fires; meaningless when ACK_TIMEOUT is 0.
    localparam logic [TMR_WIDTH-1:0] TmrLast = TMR_WIDTH'(ACK_TIMEOUT - 1);
    localparam bit                   TmrEn   = (ACK_TIMEOUT != 0);

    typedef enum logic [1:0] {
        StIdle,
        StHostReq,
        StAckNode,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [TMR_WIDTH-1:0]   timer_q, timer_d;
    logic                   node_ack_q, node_ack_d;
    logic                   host_req_q, host_req_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_WIDTH-1:0]   to_cnt_q, to_cnt_d;

    logic match;
    logic unused_addr;

    // Only the function field selects the channel; upper address bits are ignored.
    assign match       = MASTER_EN & NODE_RX_BROADCAST & DROP_MASK[NODE_RX_ADDR[FUNC_WIDTH-1:0]];
    assign unused_addr = ^NODE_RX_ADDR[ADDR_WIDTH-1:FUNC_WIDTH];

    // Next-state logic for the handshake FSM, timer and counters.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        node_ack_d = node_ack_q;
        host_req_d = host_req_q;
        timeout_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        to_cnt_d   = to_cnt_q;

        unique case (state_q)
            StIdle: begin
                // A host still holding ACK from an earlier message blocks acceptance.
                if (NODE_RX_REQ && !HOST_RX_ACK) begin
                    if (match) begin
                        state_d    = StAckNode;
                        node_ack_d = 1'b1;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        state_d    = StHostReq;
                        host_req_d = 1'b1;
                        timer_d    = '0;
                    end
                end
            end
            StHostReq: begin
                if (!NODE_RX_REQ) begin
                    // Node withdrew: never ack a message it no longer offers.
                    state_d    = StDrain;
                    host_req_d = 1'b0;
                end else if (HOST_RX_ACK) begin
                    state_d    = StAckNode;
                    host_req_d = 1'b0;
                    node_ack_d = 1'b1;
                end else if (TmrEn && (timer_q == TmrLast)) begin
                    state_d    = StAckNode;
                    host_req_d = 1'b0;
                    node_ack_d = 1'b1;
                    timeout_d  = 1'b1;
                    if (to_cnt_q != '1) begin
                        to_cnt_d = to_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_WIDTH'(1);
                end
            end
            StAckNode: begin
                if (!NODE_RX_REQ) begin
                    state_d    = StDrain;
                    node_ack_d = 1'b0;
                end
            end
            StDrain: begin
                // Absorbs a late host ACK after a timeout or withdrawal.
                if (!HOST_RX_ACK) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK_EXT) begin
        if (!RESETn) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            node_ack_q <= 1'b0;
            host_req_q <= 1'b0;
            timeout_q  <= 1'b0;
            drop_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            node_ack_q <= node_ack_d;
            host_req_q <= host_req_d;
            timeout_q  <= timeout_d;
            drop_cnt_q <= drop_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign NODE_RX_ACK   = node_ack_q;
    assign HOST_RX_REQ   = host_req_q;
    assign TIMEOUT       = timeout_q;
    assign DROP_COUNT    = drop_cnt_q;
    assign TIMEOUT_COUNT = to_cnt_q;

endmodule

// File: tb/tb_mbus_rx_channel_filter.sv
// Bench for mbus_rx_channel_filter. The main instance uses an 8-cycle timeout
// and 4-bit counters; a second instance has the timeout disabled.
// Expected waveforms are derived per message from event times (response edge,
// host ACK edge, withdraw edge) measured from the edge after NODE_RX_REQ rises.
module tb_mbus_rx_channel_filter;

    localparam int T      = 8;
    localparam int CntMax = 15;
    localparam int Never  = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        men, bc, nreq, hack;
    logic [15:0] mask;
    logic [31:0] addr;
    logic        nack, hreq, tout;
    logic [3:0]  dcnt, tcnt;

    logic        men0, bc0, nreq0, hack0;
    logic [15:0] mask0;
    logic [31:0] addr0;
    logic        nack0, hreq0, tout0;
    logic [15:0] dcnt0, tcnt0;

    int n_chk = 0;
    int n_err = 0;
    int drop_exp = 0;
    int to_exp = 0;

    always #5 clk = ~clk;

    mbus_rx_channel_filter #(
        .ACK_TIMEOUT(T),
        .CNT_WIDTH  (4)
    ) dut (
        .CLK_EXT          (clk),
        .RESETn           (rst_n),
        .MASTER_EN        (men),
        .DROP_MASK        (mask),
        .NODE_RX_ADDR     (addr),
        .NODE_RX_BROADCAST(bc),
        .NODE_RX_REQ      (nreq),
        .NODE_RX_ACK      (nack),
        .HOST_RX_REQ      (hreq),
        .HOST_RX_ACK      (hack),
        .TIMEOUT          (tout),
        .DROP_COUNT       (dcnt),
        .TIMEOUT_COUNT    (tcnt)
    );

    mbus_rx_channel_filter #(
        .ACK_TIMEOUT(0),
        .CNT_WIDTH  (16)
    ) dut0 (
        .CLK_EXT          (clk),
        .RESETn           (rst_n),
        .MASTER_EN        (men0),
        .DROP_MASK        (mask0),
        .NODE_RX_ADDR     (addr0),
        .NODE_RX_BROADCAST(bc0),
        .NODE_RX_REQ      (nreq0),
        .NODE_RX_ACK      (nack0),
        .HOST_RX_REQ      (hreq0),
        .HOST_RX_ACK      (hack0),
        .TIMEOUT          (tout0),
        .DROP_COUNT       (dcnt0),
        .TIMEOUT_COUNT    (tcnt0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One message: ch/b/me/mk define the filter decision, host raises ACK for
    // the single edge 2+k, node withdraws REQ from edge w (Never = no withdraw).
    task automatic run_msg(input int ch, input bit b, input bit me, input logic [15:0] mk,
                           input int k, input int w);
        bit drop, timed_out, withdrawn;
        int a, r, ack_edge, last, hreq_end;
        drop      = me && b && mk[ch];
        a         = 2 + k;
        timed_out = !drop && (a > T + 1);
        r         = drop ? 1 : (timed_out ? T + 1 : a);
        withdrawn = !drop && (w <= r);
        if (withdrawn) timed_out = 1'b0;
        ack_edge  = withdrawn ? 0 : r;
        hreq_end  = drop ? 1 : (withdrawn ? w : r);
        last      = drop ? 1 : ((a > hreq_end) ? a : hreq_end);

        men = me; mask = mk; bc = b;
        addr = $urandom();
        addr[3:0] = 4'(ch);
        nreq = 1'b1; hack = 1'b0;
        for (int n = 1; n <= last + 3; n++) begin
            @(posedge clk); #1;
            check_eq("host_req", hreq, (!drop && n < hreq_end) ? 1 : 0);
            check_eq("node_ack", nack, (ack_edge != 0 && n == ack_edge) ? 1 : 0);
            check_eq("timeout",  tout, (timed_out && n == r) ? 1 : 0);
            nreq = (n + 1 < w) && (ack_edge == 0 || n + 1 <= ack_edge);
            hack = !drop && (n + 1 == a);
            // Filter inputs may change freely once the message is accepted.
            men  = 1'($urandom());
            mask = 16'($urandom());
            bc   = 1'($urandom());
            addr = $urandom();
        end
        if (drop && drop_exp < CntMax) drop_exp++;
        if (timed_out && to_exp < CntMax) to_exp++;
        check_eq("drop_count", dcnt, drop_exp);
        check_eq("timeout_count", tcnt, to_exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_to, lost_req;
        rst_n = 1'b0;
        men = 0; bc = 0; nreq = 0; hack = 0; mask = '0; addr = '0;
        men0 = 0; bc0 = 0; nreq0 = 0; hack0 = 0; mask0 = '0; addr0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_node_ack", nack, 0);
        check_eq("rst_host_req", hreq, 0);
        check_eq("rst_timeout", tout, 0);
        check_eq("rst_drop_count", dcnt, 0);
        check_eq("rst_timeout_count", tcnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_msg(0, 1, 1, 16'h0001, 0, Never);   // drop
        run_msg(5, 1, 1, 16'h0001, 3, Never);   // broadcast, unmasked channel
        run_msg(0, 0, 1, 16'h0001, 3, Never);   // unicast
        run_msg(0, 1, 0, 16'h0001, 3, Never);   // filtering disabled
        run_msg(3, 0, 1, 16'hFFFF, 10, Never);  // timeout, late ACK 3 cycles after
        run_msg(3, 0, 1, 16'hFFFF, 7, Never);   // ACK on the timeout cycle
        run_msg(7, 1, 1, 16'h0000, 20, 4);      // withdraw while forwarded
        run_msg(9, 1, 1, 16'hFFFF, 0, Never);   // drop on a high channel

        // Reset during the node-ack phase of a dropped message.
        men = 1; bc = 1; mask = 16'h0001; addr = 32'h0; nreq = 1;
        @(posedge clk); #1;
        check_eq("pre_rst_node_ack", nack, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_node_ack", nack, 0);
        check_eq("mid_rst_host_req", hreq, 0);
        check_eq("mid_rst_timeout", tout, 0);
        check_eq("mid_rst_drop_count", dcnt, 0);
        check_eq("mid_rst_timeout_count", tcnt, 0);
        rst_n = 1'b1; nreq = 0;
        drop_exp = 0; to_exp = 0;
        repeat (2) @(posedge clk);
        #1;

        // Saturation of the drop counter.
        for (int i = 0; i < 20; i++) begin
            run_msg(int'($urandom_range(0, 15)), 1, 1, 16'hFFFF, 0, Never);
        end
        check_eq("drop_saturated", dcnt, 4'hF);

        // Randomised messages.
        for (int i = 0; i < 200; i++) begin
            run_msg(int'($urandom_range(0, 15)), 1'($urandom()), 1'($urandom()),
                    16'($urandom()), int'($urandom_range(0, 14)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : Never);
        end

        // Timeout disabled: a long host stall must not fire.
        seen_to = 0; lost_req = 0;
        nreq0 = 1;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clk); #1;
            if (tout0 !== 1'b0 || nack0 !== 1'b0) seen_to = 1;
            if (hreq0 !== 1'b1) lost_req = 1;
        end
        check_eq("no_timeout_stall", seen_to, 0);
        check_eq("host_req_held", lost_req, 0);
        hack0 = 1;
        @(posedge clk); #1;
        check_eq("stall_node_ack", nack0, 1);
        check_eq("stall_host_req", hreq0, 0);
        nreq0 = 0; hack0 = 0;
        @(posedge clk); #1;
        check_eq("stall_ack_release", nack0, 0);
        check_eq("stall_timeout_count", tcnt0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
